// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program loader.
//   INSTR_W        - instruction word width (16)
//   BYTES_PER_WORD - stream bytes per instruction word (2)
//   BYTE_W         - stream byte width
//   loader_state_t - loader FSM states (CSUM only reachable with LOADER_CHECKSUM_EN)
package cpu_pkg;

    localparam int INSTR_W        = 16;
    localparam int BYTES_PER_WORD = 2;
    localparam int BYTE_W         = INSTR_W / BYTES_PER_WORD;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        W_HI,
        W_LO,
        CSUM,
        HOLD,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/byte_to_word.sv
// High/low byte assembler for the program loader.
//   clk, reset  - clock, asynchronous active-high reset
//   byte_data   - incoming stream byte
//   byte_valid  - byte is being consumed this cycle
//   hi_sel      - 1: consumed byte is the high half, 0: low half (completes a word)
//   word        - {latched high byte, current low byte}
//   word_valid  - single-cycle pulse when the low byte completes a word
module byte_to_word
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  byte_data,
    input  logic               byte_valid,
    input  logic               hi_sel,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [BYTE_W-1:0] hi_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_byte <= '0;
        end else if (byte_valid && hi_sel) begin
            hi_byte <= byte_data;
        end
    end

    // The low byte is not stored: the word is complete in the cycle it arrives,
    // so the consumer can register it without an extra pipeline bubble.
    always_comb begin
        word       = {hi_byte, byte_data};
        word_valid = byte_valid && !hi_sel;
    end

endmodule

// File: rtl/program_loader.sv
// In-system boot loader: fills the CPU instruction memory from a byte stream
// (frame: N_hi, N_lo, then N words high byte first) and then releases the CPU.
// Optional macro LOADER_CHECKSUM_EN: a trailing XOR byte over header and
// payload is required; a mismatch sends the loader to ERROR.
//   clk              - system clock, rising edge
//   reset            - asynchronous, active-high; restarts header reception
//   rx_data/rx_valid - input byte stream
//   rx_ready         - byte accepted when rx_valid && rx_ready
//   instruction_in   - word presented to instruction memory
//   load_address     - instruction memory write address
//   load_instruction - memory write enable / CPU load mode
//   pc_reset         - holds the CPU PC in reset
//   done             - load complete, CPU running
//   err              - frame error, CPU held in reset
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = INSTR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] instruction_in,
    output logic [ADDR_W-1:0] load_address,
    output logic              load_instruction,
    output logic              pc_reset,
    output logic              done,
    output logic              err
);

    // Largest legal word count; the counter has one extra bit so it can reach it.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    loader_state_t        state;
    logic [7:0]           hdr_hi;
    logic [ADDR_W:0]      n_words;
    logic [ADDR_W:0]      k;
    logic [ADDR_W:0]      k_next;
    logic [31:0]          n_ext;
    logic                 accept;
    logic [INSTR_W-1:0]   word;
    logic                 word_valid;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    always_comb begin
        accept = rx_valid && rx_ready;
        n_ext  = {16'h0000, hdr_hi, rx_data};
        k_next = k + {{ADDR_W{1'b0}}, 1'b1};
    end

    byte_to_word u_b2w (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (rx_data),
        .byte_valid (accept && (state == W_HI || state == W_LO)),
        .hi_sel     (state == W_HI),
        .word       (word),
        .word_valid (word_valid)
    );

    // Outputs are registered alongside the state: every transition sets the
    // output values that belong to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= HDR_HI;
            hdr_hi           <= '0;
            n_words          <= '0;
            k                <= '0;
            instruction_in   <= '0;
            load_address     <= '0;
            load_instruction <= 1'b1;
            pc_reset         <= 1'b1;
            done             <= 1'b0;
            err              <= 1'b0;
            rx_ready         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
        end else begin
            case (state)
                HDR_HI: begin
                    // rx_ready rises on the first clock after reset release.
                    rx_ready <= 1'b1;
                    if (accept) begin
                        hdr_hi <= rx_data;
                        state  <= HDR_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= rx_data;
`endif
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_words <= n_ext[ADDR_W:0];
                        k       <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ rx_data;
`endif
                        if (n_ext == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= HOLD;
                            rx_ready <= 1'b0;
`endif
                        end else if (n_ext > MAX_WORDS) begin
                            state            <= ERROR;
                            rx_ready         <= 1'b0;
                            load_instruction <= 1'b0;
                            err              <= 1'b1;
                        end else begin
                            state <= W_HI;
                        end
                    end
                end
                W_HI: begin
                    if (accept) begin
                        state <= W_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum  <= csum ^ rx_data;
`endif
                    end
                end
                W_LO: begin
                    if (word_valid) begin
                        instruction_in <= word;
                        load_address   <= k[ADDR_W-1:0];
                        k              <= k_next;
`ifdef LOADER_CHECKSUM_EN
                        csum           <= csum ^ rx_data;
`endif
                        if (k_next == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= HOLD;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            state <= W_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state <= HOLD;
                        end else begin
                            state            <= ERROR;
                            load_instruction <= 1'b0;
                            err              <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    // One extra write cycle guarantees the last word lands.
                    state            <= RUN;
                    load_instruction <= 1'b0;
                    pc_reset         <= 1'b0;
                    done             <= 1'b1;
                end
                default: begin
                    // RUN and ERROR are terminal until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sel;   // 0: ADDR_W=16 instance, 1: ADDR_W=4 instance
    logic       rx_valid_a, rx_valid_b;

    logic        rdy_a, li_a, pcr_a, done_a, err_a;
    logic [15:0] instr_a, addr_a;
    logic        rdy_b, li_b, pcr_b, done_b, err_b;
    logic [15:0] instr_b;
    logic [3:0]  addr_b;

    logic        cur_ready, cur_li, cur_pcr, cur_done, cur_err;
    logic [15:0] cur_instr, cur_addr;

    assign rx_valid_a = rx_valid & ~sel;
    assign rx_valid_b = rx_valid & sel;

    program_loader #(.ADDR_W(16)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .rx_ready(rdy_a), .instruction_in(instr_a), .load_address(addr_a),
        .load_instruction(li_a), .pc_reset(pcr_a), .done(done_a), .err(err_a)
    );

    program_loader #(.ADDR_W(4)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .rx_ready(rdy_b), .instruction_in(instr_b), .load_address(addr_b),
        .load_instruction(li_b), .pc_reset(pcr_b), .done(done_b), .err(err_b)
    );

    always_comb begin
        if (sel) begin
            cur_ready = rdy_b; cur_li = li_b; cur_pcr = pcr_b; cur_done = done_b;
            cur_err = err_b; cur_instr = instr_b; cur_addr = {12'h000, addr_b};
        end else begin
            cur_ready = rdy_a; cur_li = li_a; cur_pcr = pcr_a; cur_done = done_a;
            cur_err = err_a; cur_instr = instr_a; cur_addr = addr_a;
        end
    end

    // Instruction memory model: written on every rising edge with write enable high.
    logic [15:0] mem_a [int];
    logic [15:0] mem_b [int];
    always @(posedge clk) begin
        if (li_a) mem_a[int'(addr_a)] = instr_a;
        if (li_b) mem_b[int'(addr_b)] = instr_b;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0]  tx[$];
    logic [15:0] words[$];

    function automatic logic [31:0] mem_read(input int a);
        if (sel) return mem_b.exists(a) ? {16'h0, mem_b[a]} : 32'h0001_0000;
        return mem_a.exists(a) ? {16'h0, mem_a[a]} : 32'h0001_0000;
    endfunction

    function automatic int mem_count();
        return sel ? mem_b.num() : mem_a.num();
    endfunction

    // Reference: payload words are the byte pairs following the header.
    task automatic derive_words();
        int n;
        n = int'({tx[0], tx[1]});
        words.delete();
        for (int i = 0; i < n; i++)
            if (3 + 2 * i < tx.size()) words.push_back({tx[2 + 2 * i], tx[3 + 2 * i]});
    endtask

    task automatic make_frame(input int n);
        logic [15:0] nn;
        nn = 16'(n);
        tx.delete();
        tx.push_back(nn[15:8]);
        tx.push_back(nn[7:0]);
        for (int i = 0; i < 2 * n; i++) tx.push_back(8'($urandom));
        derive_words();
    endtask

    task automatic append_csum(input bit bad);
        logic [7:0] x;
        x = '0;
        foreach (tx[i]) x ^= tx[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
`ifdef LOADER_CHECKSUM_EN
        tx.push_back(x);
`endif
    endtask

    task automatic do_reset(input bit clear_mem);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cur_ready), 0);
        check("rst_ld", 32'(cur_li), 1);
        check("rst_pcrst", 32'(cur_pcr), 1);
        check("rst_done", 32'(cur_done), 0);
        check("rst_err", 32'(cur_err), 0);
        check("rst_instr", 32'(cur_instr), 0);
        check("rst_addr", 32'(cur_addr), 0);
        reset = 1'b0;
        @(negedge clk);
        if (clear_mem) begin
            mem_a.delete();
            mem_b.delete();
        end
    endtask

    // Sends the first nsend bytes of tx, checking the load interface every cycle
    // against the words completed so far. Called and returns just after a negedge.
    task automatic stream(input int nsend, input bit gaps, output int cycles);
        int acc, n, w;
        bit take;
        acc = 0;
        cycles = 0;
        n = int'({tx[0], tx[1]});
        while (acc < nsend) begin
            w = (acc < 2) ? 0 : (acc - 2) / 2;
            if (w > n) w = n;
            if (w > words.size()) w = words.size();
            check("instr", 32'(cur_instr), (w > 0) ? 32'(words[w - 1]) : 32'd0);
            check("addr", 32'(cur_addr), (w > 0) ? 32'(w - 1) : 32'd0);
            check("ready", 32'(cur_ready), 1);
            check("ld", 32'(cur_li), 1);
            check("pcrst", 32'(cur_pcr), 1);
            check("done", 32'(cur_done), 0);
            check("err", 32'(cur_err), 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data = tx[acc];
            end
            take = rx_valid && cur_ready;
            @(negedge clk);
            cycles++;
            if (take) acc++;
            if (cycles > 3000) begin
                check("stream_timeout", 1, 0);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish(input bit expect_err, input int n, input bit count_mem);
        if (!expect_err) begin
            check("hold_ld", 32'(cur_li), 1);
            check("hold_pcrst", 32'(cur_pcr), 1);
            check("hold_done", 32'(cur_done), 0);
            check("hold_ready", 32'(cur_ready), 0);
            @(negedge clk);
        end
        repeat (3) begin
            check("end_done", 32'(cur_done), expect_err ? 0 : 1);
            check("end_err", 32'(cur_err), expect_err ? 1 : 0);
            check("end_ld", 32'(cur_li), 0);
            check("end_pcrst", 32'(cur_pcr), expect_err ? 1 : 0);
            check("end_ready", 32'(cur_ready), 0);
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!expect_err) begin
            for (int i = 0; i < n; i++) check("mem", mem_read(i), 32'(words[i]));
            if (n == 0) check("mem0", mem_read(0), 0);
            if (count_mem) check("mem_count", 32'(mem_count()), (n == 0) ? 1 : 32'(n));
        end
    endtask

    initial begin
        int cyc, n;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        sel = 1'b0;

        // Two-word frame, no gaps: one accept per cycle, no bubbles.
        do_reset(1);
        tx = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        derive_words();
        append_csum(0);
        stream(tx.size(), 0, cyc);
        check("accept_cycles", 32'(cyc), 32'(tx.size()));
        finish(0, 2, 1);

        // Empty program.
        do_reset(1);
        tx = '{8'h00, 8'h00};
        derive_words();
        append_csum(0);
        stream(tx.size(), 0, cyc);
        finish(0, 0, 1);

        // Reset in the middle of a frame, then a fresh one-word frame.
        do_reset(1);
        tx = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
        derive_words();
        stream(5, 0, cyc);
        do_reset(0);
        tx = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        derive_words();
        append_csum(0);
        stream(tx.size(), 0, cyc);
        finish(0, 1, 0);
        check("restart_mem0", mem_read(0), 32'h0000_BEEF);

        // Random frames with random rx_valid gaps (first one is a 4-word frame).
        for (int t = 0; t < 5; t++) begin
            n = (t == 0) ? 4 : int'($urandom_range(1, 8));
            do_reset(1);
            make_frame(n);
            append_csum(0);
            stream(tx.size(), 1, cyc);
            finish(0, n, 1);
        end

        // Small address space: full 16-word program is legal, 17 words is not.
        sel = 1'b1;
        do_reset(1);
        make_frame(16);
        append_csum(0);
        stream(tx.size(), 1, cyc);
        finish(0, 16, 1);

        do_reset(1);
        tx = '{8'h00, 8'h11};
        derive_words();
        stream(2, 0, cyc);
        finish(1, 17, 0);
        sel = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        // Checksum covers header and payload bytes.
        do_reset(1);
        tx = '{8'h00, 8'h01, 8'h12, 8'h34};
        derive_words();
        append_csum(0);
        stream(tx.size(), 0, cyc);
        finish(0, 1, 1);

        do_reset(1);
        tx = '{8'h00, 8'h01, 8'h12, 8'h34};
        derive_words();
        append_csum(1);
        stream(tx.size(), 0, cyc);
        finish(1, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
